life_row_scanner: RTL
=====================

# life_row_scanner

Downstream display stage for the 16x16 life generator. Accepts each 256-bit generation through a valid/ready handshake, double-buffers it, and multiplexes it row by row onto a 16-row by 16-column LED matrix. Frames never tear: a new grid is swapped in only at frame boundaries. `frame_done` is the pacing pulse that top-level logic uses to drive the generator's `start`.

## Interface
- DWELL, default 1000: cycles each row is lit.
- BLANK, default 8: all-off cycles between rows (anti-ghosting), minimum 1.
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high.
- grid_in  input  256  generation from generator `gout`. Row r = grid_in[16*(15-r)+15 : 16*(15-r)]. Column c = bit c of that row.
- grid_valid  input  1  grid_in holds a new generation.
- grid_ready  output  1  pending buffer empty. Transfer occurs on any edge with grid_valid & grid_ready.
- row_sel  output  16  one-hot active-high row drive. Bit r lights row r.
- col_data  output  16  column data for the lit row. All zero whenever row_sel is zero.
- frame_done  output  1  one-cycle pulse at the end of each scanned frame.
- extinct  output  1  the displayed grid is all zero (valid while scanning).

## Operation
- Registers:
  - pending[255:0] and pending_full.
  - display[255:0].
  - state, row[3:0], and a timer sized for max(DWELL, BLANK).
- grid_ready = !pending_full.
- On handshake: pending <= grid_in and pending_full <= 1. While full, grid_valid is ignored and the upstream holds its value.
- State machine:
  - IDLE: outputs off. If pending_full: display <= pending, pending_full <= 0, row <= 0, timer <= 0, go LIT.
  - LIT: row_sel = 1<<row, col_data = row r of display. Count DWELL cycles, then go DARK with timer cleared.
  - DARK: outputs off. Count BLANK cycles.
    - If row != 15: row++ and go LIT.
    - If row == 15: assert frame_done for this final DARK cycle. Then:
      - if pending_full: display <= pending, pending_full <= 0, row <= 0, go LIT;
      - otherwise: row <= 0, go LIT, rescanning the same display.
- The scanner never returns to IDLE except through reset.
- extinct = (display == 0) when state != IDLE, otherwise 0.
- Boundary cases:
  - Handshake and frame-boundary swap on the same edge: the swap uses the registered pending_full, so it cannot occur while ready is high. The newly captured grid waits for the next boundary. There is no loss and no tear.
  - Two generations within one frame: the second is back-pressured, never overwritten.
  - Reset mid-frame: all registers return to their reset values immediately. pending is discarded.

## Timing
- Reset values:
  - state IDLE, row 0, timer 0;
  - pending_full 0, display 0, pending 0;
  - row_sel 0, col_data 0, frame_done 0, extinct 0;
  - grid_ready 1.
- Outputs are combinational decodes of registered state, row, timer and display. There are no input-to-output combinational paths except grid_valid into the capture enable.
- First-frame latency:
  - handshake on edge N;
  - swap into display and entry to LIT on edge N+1;
  - row_sel = 0x0001 during the cycle after edge N+1.
- Row period is DWELL+BLANK cycles. Frame period is 16*(DWELL+BLANK) cycles. frame_done has exactly this period.
- grid_ready returns to 1 in the cycle after the boundary swap edge.

## Structure
- Package life_pkg holds:
  - ROWS=16, COLS=16, GRID_W=256;
  - typedef enum logic [1:0] {SCAN_IDLE, SCAN_LIT, SCAN_DARK} scan_state_t;
  - function get_row(grid, r) implementing the row mapping. The generator testbench shares the same function.
- One sub-module, scan_timer: a loadable up-counter with clear and a terminal-count compare against a runtime limit (DWELL or BLANK). The FSM, buffers and output decode stay in life_row_scanner.

## Test plan
All scenarios use DWELL=4 and BLANK=1, giving a 5-cycle row and an 80-cycle frame.
- Reset with grid_valid low -> row_sel=0, col_data=0, grid_ready=1, frame_done never pulses, state stays IDLE.
- Single handshake on grid_in with row 0 = 0x8001 and row 15 = 0xFFFF:
  - 1 cycle later, row_sel=0x0001 with col_data=0x8001 for 4 cycles, then 1 cycle all zero;
  - row 15 shows 0xFFFF;
  - frame_done pulses at cycle 80 of the frame and repeats every 80 cycles.
- Second grid (all 0x5555 rows) presented at cycle 20 of a frame:
  - accepted, then grid_ready=0 until the boundary;
  - display unchanged through row 15;
  - row 0 of the next frame shows 0x5555.
- Third grid held valid while pending is full -> not captured until the cycle after the swap edge. It appears one frame later. No grid is dropped or reordered.
- All-zero grid loaded -> extinct=1 throughout the scan. Loading the 0x5555 grid -> extinct=0 from the swap cycle onward.
- Reset asserted during row 7 with pending full -> all outputs return to reset values asynchronously. grid_ready=1. After release, no scanning until a new handshake.

Source files
------------

// File: rtl/life_pkg.sv
// life_pkg: shared grid geometry, scanner state encoding and the row-extraction helper
package life_pkg;
  localparam int ROWS = 16;
  localparam int COLS = 16;
  localparam int GRID_W = ROWS * COLS;
  typedef enum logic [1:0] {SCAN_IDLE, SCAN_LIT, SCAN_DARK} scan_state_t;
  // Row 0 occupies the most significant 16 bits of the grid vector.
  function automatic logic [COLS-1:0] get_row(input logic [GRID_W-1:0] grid, input logic [3:0] r);
    return grid[COLS*(ROWS-1-int'(r)) +: COLS];
  endfunction
endpackage

// File: rtl/life_row_scanner_scan_timer.sv
// scan_timer: up-counter with clear; tc_o flags the cycle the count reaches limit_i
//   clk/reset  clock and async active-high reset
//   clr_i      restart the count from zero on the next edge
//   limit_i    terminal count (phase length minus one)
//   tc_o       count equals limit
module scan_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic [W-1:0] limit_i,
  output logic         tc_o
);
  logic [W-1:0] count_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) count_q <= '0;
    else count_q <= clr_i ? '0 : count_q + W'(1);
  assign tc_o = count_q == limit_i;
endmodule

// File: rtl/life_row_scanner.sv
// life_row_scanner: double-buffered, tear-free row multiplexer for a 16x16 LED matrix
//   clk/reset   clock and async active-high reset
//   grid_in     256-bit generation, captured on grid_valid & grid_ready
//   grid_ready  pending buffer empty
//   row_sel     one-hot row drive, col_data columns of the lit row
//   frame_done  one-cycle pulse in the last blank cycle of each frame
//   extinct     displayed grid is all zero while scanning
module life_row_scanner
  import life_pkg::*;
#(
  parameter int DWELL = 1000,
  parameter int BLANK = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [GRID_W-1:0] grid_in,
  input  logic              grid_valid,
  output logic              grid_ready,
  output logic [ROWS-1:0]   row_sel,
  output logic [COLS-1:0]   col_data,
  output logic              frame_done,
  output logic              extinct
);
  localparam int TMAX = DWELL > BLANK ? DWELL : BLANK;
  localparam int TW = $clog2(TMAX + 1);
  logic [GRID_W-1:0] pending_q, display_q;
  logic              pending_full_q;
  scan_state_t       state_q;
  logic [3:0]        row_q;
  logic [TW-1:0]     limit;
  logic              tc, capture, last_dark, swap;
  assign grid_ready = !pending_full_q;
  assign capture = grid_valid & grid_ready;
  assign last_dark = state_q == SCAN_DARK && tc && row_q == 4'd15;
  // Capture needs an empty buffer and swap needs a full one, so they never coincide.
  assign swap = pending_full_q & (state_q == SCAN_IDLE | last_dark);
  assign limit = state_q == SCAN_LIT ? TW'(DWELL - 1) : TW'(BLANK - 1);
  scan_timer #(.W(TW)) u_timer (
    .clk(clk),
    .reset(reset),
    .clr_i(state_q == SCAN_IDLE || tc),
    .limit_i(limit),
    .tc_o(tc)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pending_q      <= '0;
      display_q      <= '0;
      pending_full_q <= 1'b0;
      state_q        <= SCAN_IDLE;
      row_q          <= '0;
    end else begin
      if (capture) pending_q <= grid_in;
      pending_full_q <= capture | (pending_full_q & !swap);
      if (swap) display_q <= pending_q;
      case (state_q)
        SCAN_IDLE: if (pending_full_q) begin
          state_q <= SCAN_LIT;
          row_q   <= '0;
        end
        SCAN_LIT: if (tc) state_q <= SCAN_DARK;
        // Row 15 wraps to 0, rescanning the same or the freshly swapped grid.
        SCAN_DARK: if (tc) begin
          state_q <= SCAN_LIT;
          row_q   <= row_q + 4'd1;
        end
        default: state_q <= SCAN_IDLE;
      endcase
    end
  assign row_sel    = state_q == SCAN_LIT ? ROWS'(1) << row_q : '0;
  assign col_data   = state_q == SCAN_LIT ? get_row(display_q, row_q) : '0;
  assign frame_done = last_dark;
  assign extinct    = state_q != SCAN_IDLE && display_q == '0;
endmodule
